// File: rtl/gpio_regbank_v2.sv
// GPIO register bank with synchronised and debounced inputs, per-pin edge interrupts,
// write-1-to-clear status, atomic OUT set/clear/toggle aliases and AUX output muxing.
module gpio_regbank_v2 #(
  parameter int GPIO_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 8
) (
  input  logic              sysclk,
  input  logic              sysrst,
  input  logic              gpio_we,
  input  logic [ADDR_W-1:0] gpio_addr,
  input  logic [31:0]       gpio_dat_i,
  output logic [31:0]       gpio_dat_o,
  output logic              gpio_inta_o,
  input  logic [GPIO_W-1:0] aux_i,
  input  logic [GPIO_W-1:0] in_pad_i,
  output logic [GPIO_W-1:0] out_pad_o,
  output logic [GPIO_W-1:0] oen_padoen_o
);

  localparam logic [ADDR_W-1:0] A_IN     = ADDR_W'(6'h00);
  localparam logic [ADDR_W-1:0] A_OUT    = ADDR_W'(6'h04);
  localparam logic [ADDR_W-1:0] A_OE     = ADDR_W'(6'h08);
  localparam logic [ADDR_W-1:0] A_INTE   = ADDR_W'(6'h0C);
  localparam logic [ADDR_W-1:0] A_PTRIG  = ADDR_W'(6'h10);
  localparam logic [ADDR_W-1:0] A_BOTH   = ADDR_W'(6'h14);
  localparam logic [ADDR_W-1:0] A_AUX    = ADDR_W'(6'h18);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(6'h1C);
  localparam logic [ADDR_W-1:0] A_INTS   = ADDR_W'(6'h20);
  localparam logic [ADDR_W-1:0] A_SET    = ADDR_W'(6'h24);
  localparam logic [ADDR_W-1:0] A_CLR    = ADDR_W'(6'h28);
  localparam logic [ADDR_W-1:0] A_TGL    = ADDR_W'(6'h2C);
  localparam logic [ADDR_W-1:0] A_DEBEN  = ADDR_W'(6'h30);
  localparam logic [ADDR_W-1:0] A_DEBDIV = ADDR_W'(6'h34);

  localparam logic [GPIO_W-1:0] PINS_ZERO = {GPIO_W{1'b0}};
  localparam logic [DEB_W-1:0]  CNT_ZERO  = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0]  CNT_ONE   = DEB_W'(1'b1);

  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] in_q;
  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] oe_q, oe_d;
  logic [GPIO_W-1:0] inte_q, inte_d;
  logic [GPIO_W-1:0] ptrig_q, ptrig_d;
  logic [GPIO_W-1:0] both_q, both_d;
  logic [GPIO_W-1:0] aux_q, aux_d;
  logic [GPIO_W-1:0] ints_q, ints_d;
  logic [GPIO_W-1:0] deben_q, deben_d;
  logic [GPIO_W-1:0] hist0_q, hist0_d;
  logic [GPIO_W-1:0] hist1_q, hist1_d;
  logic [GPIO_W-1:0] deb_q, deb_d;
  logic              ctrl_inte_q, ctrl_inte_d;
  logic              ctrl_ints_q, ctrl_ints_d;
  logic [DEB_W-1:0]  debdiv_q, debdiv_d;
  logic [DEB_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [GPIO_W-1:0] pad_sync, filt, wdat, w1c, evt, stable;
  logic              tick, debdiv_wr, ctrl_wr;

  // Filtered input selection and per-pin edge events (f vs. last sampled IN)
  always_comb begin
    pad_sync = sync_q[SYNC_STAGES-1];
    filt     = (deben_q & deb_q) | (~deben_q & pad_sync);
    evt      = (filt ^ in_q) & inte_q & (both_q | ~(ptrig_q ^ filt));
    wdat     = gpio_dat_i[GPIO_W-1:0];
  end

  // Shared debounce prescaler and 3-sample agreement filter
  always_comb begin
    tick   = (tick_cnt_q == debdiv_q);
    stable = ~(pad_sync ^ hist0_q) & ~(pad_sync ^ hist1_q);
    if (debdiv_wr) begin
      tick_cnt_d = CNT_ZERO;
    end else if (tick) begin
      tick_cnt_d = CNT_ZERO;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_ONE;
    end
    if (tick) begin
      hist0_d = pad_sync;
      hist1_d = hist0_q;
      deb_d   = (stable & pad_sync) | (~stable & deb_q);
    end else begin
      hist0_d = hist0_q;
      hist1_d = hist1_q;
      deb_d   = deb_q;
    end
  end

  // Register write decode, including the atomic OUT aliases
  always_comb begin
    out_d       = out_q;
    oe_d        = oe_q;
    inte_d      = inte_q;
    ptrig_d     = ptrig_q;
    both_d      = both_q;
    aux_d       = aux_q;
    deben_d     = deben_q;
    debdiv_d    = debdiv_q;
    ctrl_inte_d = ctrl_inte_q;
    w1c         = PINS_ZERO;
    debdiv_wr   = 1'b0;
    ctrl_wr     = 1'b0;
    if (gpio_we) begin
      case (gpio_addr)
        A_OUT:    out_d   = wdat;
        A_OE:     oe_d    = wdat;
        A_INTE:   inte_d  = wdat;
        A_PTRIG:  ptrig_d = wdat;
        A_BOTH:   both_d  = wdat;
        A_AUX:    aux_d   = wdat;
        A_CTRL: begin
          ctrl_inte_d = gpio_dat_i[0];
          ctrl_wr     = 1'b1;
        end
        A_INTS:   w1c     = wdat;
        A_SET:    out_d   = out_q | wdat;
        A_CLR:    out_d   = out_q & ~wdat;
        A_TGL:    out_d   = out_q ^ wdat;
        A_DEBEN:  deben_d = wdat;
        A_DEBDIV: begin
          debdiv_d  = gpio_dat_i[DEB_W-1:0];
          debdiv_wr = 1'b1;
        end
        default:  w1c     = PINS_ZERO;
      endcase
    end else begin
      w1c = PINS_ZERO;
    end
  end

  // Status update: a same-cycle event beats its W1C; the sticky flag follows the request
  always_comb begin
    if (ctrl_inte_q) begin
      ints_d = (ints_q & ~w1c) | evt;
    end else begin
      ints_d = ints_q & ~w1c;
    end
    if (gpio_inta_o) begin
      ctrl_ints_d = 1'b1;
    end else if (ctrl_wr) begin
      ctrl_ints_d = gpio_dat_i[1];
    end else begin
      ctrl_ints_d = ctrl_ints_q;
    end
  end

  // Read mux, sampled into gpio_dat_o on every edge
  always_comb begin
    case (gpio_addr)
      A_IN:     rdata_d = 32'(in_q);
      A_OUT:    rdata_d = 32'(out_q);
      A_OE:     rdata_d = 32'(oe_q);
      A_INTE:   rdata_d = 32'(inte_q);
      A_PTRIG:  rdata_d = 32'(ptrig_q);
      A_BOTH:   rdata_d = 32'(both_q);
      A_AUX:    rdata_d = 32'(aux_q);
      A_CTRL:   rdata_d = {30'd0, ctrl_ints_q, ctrl_inte_q};
      A_INTS:   rdata_d = 32'(ints_q);
      A_DEBEN:  rdata_d = 32'(deben_q);
      A_DEBDIV: rdata_d = 32'(debdiv_q);
      default:  rdata_d = 32'd0;
    endcase
  end

  // Input synchroniser chain
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= PINS_ZERO;
      end
    end else begin
      sync_q[0] <= in_pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Software-visible configuration registers
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      out_q       <= PINS_ZERO;
      oe_q        <= PINS_ZERO;
      inte_q      <= PINS_ZERO;
      ptrig_q     <= PINS_ZERO;
      both_q      <= PINS_ZERO;
      aux_q       <= PINS_ZERO;
      deben_q     <= PINS_ZERO;
      debdiv_q    <= CNT_ZERO;
      ctrl_inte_q <= 1'b0;
      ctrl_ints_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      oe_q        <= oe_d;
      inte_q      <= inte_d;
      ptrig_q     <= ptrig_d;
      both_q      <= both_d;
      aux_q       <= aux_d;
      deben_q     <= deben_d;
      debdiv_q    <= debdiv_d;
      ctrl_inte_q <= ctrl_inte_d;
      ctrl_ints_q <= ctrl_ints_d;
    end
  end

  // Input sample, interrupt status and debounce state
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      in_q       <= PINS_ZERO;
      ints_q     <= PINS_ZERO;
      hist0_q    <= PINS_ZERO;
      hist1_q    <= PINS_ZERO;
      deb_q      <= PINS_ZERO;
      tick_cnt_q <= CNT_ZERO;
    end else begin
      in_q       <= filt;
      ints_q     <= ints_d;
      hist0_q    <= hist0_d;
      hist1_q    <= hist1_d;
      deb_q      <= deb_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Registered read data
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign gpio_dat_o   = rdata_q;
  assign gpio_inta_o  = ctrl_inte_q & (|ints_q);
  assign out_pad_o    = (out_q & ~aux_q) | (aux_q & aux_i);
  assign oen_padoen_o = oe_q;

endmodule

// File: tb/tb_gpio_regbank_v2.sv
// Bench for gpio_regbank_v2: directed scenarios plus random traffic, all checked
// every cycle against a per-pin behavioural model of the register bank.
module tb_gpio_regbank_v2;

  localparam int GW = 8;
  localparam int AW = 8;
  localparam int SS = 2;
  localparam int DW = 8;

  logic          sysclk     = 1'b0;
  logic          sysrst     = 1'b1;
  logic          gpio_we    = 1'b0;
  logic [AW-1:0] gpio_addr  = 8'h00;
  logic [31:0]   gpio_dat_i = 32'h0;
  logic [31:0]   gpio_dat_o;
  logic          gpio_inta_o;
  logic [GW-1:0] aux_i      = 8'h00;
  logic [GW-1:0] in_pad_i   = 8'h00;
  logic [GW-1:0] out_pad_o;
  logic [GW-1:0] oen_padoen_o;

  always #5 sysclk = ~sysclk;

  gpio_regbank_v2 #(.GPIO_W(GW), .ADDR_W(AW), .SYNC_STAGES(SS), .DEB_W(DW)) dut (
    .sysclk(sysclk), .sysrst(sysrst), .gpio_we(gpio_we), .gpio_addr(gpio_addr),
    .gpio_dat_i(gpio_dat_i), .gpio_dat_o(gpio_dat_o), .gpio_inta_o(gpio_inta_o),
    .aux_i(aux_i), .in_pad_i(in_pad_i), .out_pad_o(out_pad_o), .oen_padoen_o(oen_padoen_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: register contents, pad delay line, debounce samples
  logic [GW-1:0] m_in, m_out, m_oe, m_inte, m_ptrig, m_both, m_aux, m_ints, m_deben;
  logic [GW-1:0] m_h0, m_h1, m_deb;
  logic          m_cinte, m_cints;
  logic [DW-1:0] m_div;
  int            m_cnt;
  logic [31:0]   m_rd;
  logic [GW-1:0] pad_q[$];

  logic          r_we;
  logic [7:0]    r_addr;
  logic [31:0]   r_dat;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 8'h0; m_out = 8'h0; m_oe = 8'h0; m_inte = 8'h0; m_ptrig = 8'h0;
    m_both = 8'h0; m_aux = 8'h0; m_ints = 8'h0; m_deben = 8'h0;
    m_h0 = 8'h0; m_h1 = 8'h0; m_deb = 8'h0;
    m_cinte = 1'b0; m_cints = 1'b0; m_div = 8'h0; m_cnt = 0; m_rd = 32'h0;
    pad_q.delete();
    for (int i = 0; i < SS; i++) pad_q.push_back(8'h0);
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return {24'h0, m_in};
      8'h04: return {24'h0, m_out};
      8'h08: return {24'h0, m_oe};
      8'h0C: return {24'h0, m_inte};
      8'h10: return {24'h0, m_ptrig};
      8'h14: return {24'h0, m_both};
      8'h18: return {24'h0, m_aux};
      8'h1C: return {30'h0, m_cints, m_cinte};
      8'h20: return {24'h0, m_ints};
      8'h30: return {24'h0, m_deben};
      8'h34: return {24'h0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  // Work out what the bank must hold after the coming edge, then wait for it
  task automatic step();
    logic [GW-1:0] s, wd, n_in, n_ints, n_h0, n_h1, n_deb;
    logic [GW-1:0] n_out, n_oe, n_inte, n_ptrig, n_both, n_aux, n_deben;
    logic [DW-1:0] n_div;
    logic          n_cinte, n_cints, tick, inta_now, f, ev, clr;
    logic [31:0]   n_rd;
    int            n_cnt;
    s        = pad_q[0];
    wd       = gpio_dat_i[GW-1:0];
    tick     = (m_cnt == int'(m_div));
    inta_now = m_cinte && (m_ints != 8'h0);
    n_rd     = model_read(gpio_addr);
    for (int p = 0; p < GW; p++) begin
      f = m_deben[p] ? m_deb[p] : s[p];
      n_in[p] = f;
      ev = 1'b0;
      if (m_inte[p] && (f != m_in[p])) begin
        if (m_both[p]) ev = 1'b1;
        else if (m_ptrig[p]) ev = f;
        else ev = !f;
      end
      clr = gpio_we && (gpio_addr == 8'h20) && wd[p];
      if (m_cinte && ev) n_ints[p] = 1'b1;
      else if (clr) n_ints[p] = 1'b0;
      else n_ints[p] = m_ints[p];
      if (tick) begin
        n_h0[p]  = s[p];
        n_h1[p]  = m_h0[p];
        n_deb[p] = (s[p] == m_h0[p] && s[p] == m_h1[p]) ? s[p] : m_deb[p];
      end else begin
        n_h0[p] = m_h0[p]; n_h1[p] = m_h1[p]; n_deb[p] = m_deb[p];
      end
    end
    n_out = m_out; n_oe = m_oe; n_inte = m_inte; n_ptrig = m_ptrig; n_both = m_both;
    n_aux = m_aux; n_deben = m_deben; n_div = m_div; n_cinte = m_cinte;
    if (gpio_we) begin
      case (gpio_addr)
        8'h04: n_out   = wd;
        8'h08: n_oe    = wd;
        8'h0C: n_inte  = wd;
        8'h10: n_ptrig = wd;
        8'h14: n_both  = wd;
        8'h18: n_aux   = wd;
        8'h1C: n_cinte = gpio_dat_i[0];
        8'h24: n_out   = m_out | wd;
        8'h28: n_out   = m_out & ~wd;
        8'h2C: n_out   = m_out ^ wd;
        8'h30: n_deben = wd;
        8'h34: n_div   = gpio_dat_i[7:0];
        default: ;
      endcase
    end
    if (gpio_we && gpio_addr == 8'h34) n_cnt = 0;
    else if (tick) n_cnt = 0;
    else n_cnt = m_cnt + 1;
    if (inta_now) n_cints = 1'b1;
    else if (gpio_we && gpio_addr == 8'h1C) n_cints = gpio_dat_i[1];
    else n_cints = m_cints;
    @(posedge sysclk);
    if (sysrst) begin
      model_reset();
    end else begin
      m_in = n_in; m_ints = n_ints; m_h0 = n_h0; m_h1 = n_h1; m_deb = n_deb;
      m_out = n_out; m_oe = n_oe; m_inte = n_inte; m_ptrig = n_ptrig; m_both = n_both;
      m_aux = n_aux; m_deben = n_deben; m_div = n_div; m_cinte = n_cinte;
      m_cints = n_cints; m_cnt = n_cnt; m_rd = n_rd;
      pad_q.push_back(in_pad_i);
      void'(pad_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    cmp("dat_o", gpio_dat_o, m_rd);
    cmp("inta", {31'h0, gpio_inta_o}, {31'h0, m_cinte && (m_ints != 8'h0)});
    cmp("out_pad", {24'h0, out_pad_o}, {24'h0, (m_out & ~m_aux) | (m_aux & aux_i)});
    cmp("oen", {24'h0, oen_padoen_o}, {24'h0, m_oe});
  endtask

  task automatic cycle(input logic we, input logic [7:0] a, input logic [31:0] d);
    gpio_we = we; gpio_addr = a; gpio_dat_i = d;
    step();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 32'h0);
  endtask

  task automatic rd_lit(input string name, input logic [7:0] a, input logic [31:0] exp);
    cycle(1'b0, a, 32'h0);
    cmp(name, gpio_dat_o, exp);
  endtask

  initial begin
    model_reset();
    idle(3);
    #2 sysrst = 1'b0;

    // Reset values and masking of unused bits
    for (int a = 0; a < 16; a++) rd_lit("rst_read", 8'(a * 4), 32'h0);
    wr(8'h08, 32'hFFFF_FFFF);
    rd_lit("oe_mask", 8'h08, 32'h0000_00FF);

    // Atomic OUT aliases
    wr(8'h04, 32'h0F);
    wr(8'h24, 32'hF0);
    rd_lit("out_set", 8'h04, 32'hFF);
    wr(8'h28, 32'h11);
    rd_lit("out_clr", 8'h04, 32'hEE);
    wr(8'h2C, 32'h0F);
    rd_lit("out_tgl", 8'h04, 32'hE1);
    cmp("out_pad_lit", {24'h0, out_pad_o}, 32'hE1);
    rd_lit("set_reads0", 8'h24, 32'h0);

    // Rising on pad0, falling on pad1 (both-edge); latency SYNC_STAGES+1
    in_pad_i = 8'h02;
    idle(5);
    wr(8'h0C, 32'h3); wr(8'h1C, 32'h1); wr(8'h10, 32'h1); wr(8'h14, 32'h2);
    in_pad_i = 8'h01;
    idle(1); cmp("edge_lat1", {31'h0, gpio_inta_o}, 32'h0);
    idle(1); cmp("edge_lat2", {31'h0, gpio_inta_o}, 32'h0);
    idle(1); cmp("edge_lat3", {31'h0, gpio_inta_o}, 32'h1);
    rd_lit("ints_both", 8'h20, 32'h3);
    wr(8'h20, 32'h3);
    in_pad_i = 8'h00;
    idle(5);
    rd_lit("fall_no_evt", 8'h20, 32'h0);

    // Event beats W1C on the same edge; sticky CTRL.INTS
    in_pad_i = 8'h01; idle(5);
    in_pad_i = 8'h00; idle(5);
    in_pad_i = 8'h01;
    idle(2);
    wr(8'h20, 32'h1);
    rd_lit("evt_wins", 8'h20, 32'h1);
    wr(8'h20, 32'h1);
    cmp("w1c_inta", {31'h0, gpio_inta_o}, 32'h0);
    rd_lit("w1c_ints", 8'h20, 32'h0);
    rd_lit("ctrl_sticky", 8'h1C, 32'h3);
    wr(8'h1C, 32'h1);
    rd_lit("ctrl_clr", 8'h1C, 32'h1);

    // Debounce: a 2-tick glitch is rejected, a long level is accepted
    in_pad_i = 8'h00; idle(6);
    wr(8'h30, 32'h1); wr(8'h34, 32'h3);
    in_pad_i = 8'h01; idle(8);
    in_pad_i = 8'h00; idle(16);
    rd_lit("deb_glitch", 8'h00, 32'h0);
    in_pad_i = 8'h01; idle(20);
    rd_lit("deb_hold", 8'h00, 32'h1);

    // Asynchronous reset mid-operation
    rd_lit("pre_rst_oe", 8'h08, 32'hFF);
    cmp("pre_rst_inta", {31'h0, gpio_inta_o}, 32'h1);
    #2 sysrst = 1'b1;
    #1;
    cmp("rst_dat", gpio_dat_o, 32'h0);
    cmp("rst_inta", {31'h0, gpio_inta_o}, 32'h0);
    cmp("rst_out", {24'h0, out_pad_o}, 32'h0);
    cmp("rst_oen", {24'h0, oen_padoen_o}, 32'h0);
    model_reset();
    idle(3);
    #2 sysrst = 1'b0;
    idle(8);
    rd_lit("rst_rise_masked", 8'h20, 32'h0);
    rd_lit("rst_in_high", 8'h00, 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) in_pad_i = in_pad_i ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) aux_i = 8'($urandom);
      r_we = ($urandom_range(0, 3) == 0);
      r_addr = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15) * 4);
      r_dat = $urandom;
      if (r_addr == 8'h34) r_dat = 32'($urandom_range(0, 4));
      cycle(r_we, r_addr, r_dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
